ddr_word_serializer: RTL and testbench

- Parametrised successor to the single-bit ODDR behavioural model used in the KC705 TS-to-ASI path.
- Accepts WORD_W-bit symbols (8b10b-coded ASI) for LANES lanes in lockstep via valid/ready and buffers them in a small FIFO.
- Emits two bits per lane per clock as rising/falling pairs (d0/d1) for the downstream ODDR.
- On FIFO underflow it inserts a fill word (K28.5 comma) so the ASI line never stalls.

---
 rtl/ts2asi_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/ddr_word_serializer.sv | 138 +++++++++++++
 tb/tb_ddr_word_serializer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts2asi_pkg.sv
// Shared definitions for the TS-to-ASI output path: K28.5 comma symbols,
// the phase counter type, serializer states and a constant log2 helper.
package ts2asi_pkg;

    // K28.5 comma in both running disparities, bit 0 transmitted first
    localparam logic [9:0] K28_5_RDN = 10'h17C;
    localparam logic [9:0] K28_5_RDP = 10'h283;

    // Phase counter is wide enough for symbols up to 512 bits
    localparam int PHASE_W = 8;
    typedef logic [PHASE_W-1:0] phase_t;

    // FILL transmits only idle words; DATA is streaming queued symbols
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_DATA = 1'b1
    } ser_state_t;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with extra pointer MSB to tell full from
// empty. Writes to a full FIFO and reads from an empty one are ignored.
module sync_fifo
    import ts2asi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  level
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Advance each pointer only on an accepted transfer
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, no reset needed since empty masks stale entries
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/ddr_word_serializer.sv
// Serializes WORD_W-bit symbols on LANES lanes into rising/falling bit
// pairs for an ODDR, LSB first, inserting IDLE_WORD whenever the FIFO
// runs dry so the line never stalls.
module ddr_word_serializer
    import ts2asi_pkg::*;
#(
    parameter int                LANES      = 1,
    parameter int                WORD_W     = 10,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [WORD_W-1:0] IDLE_WORD  = WORD_W'(K28_5_RDN),
    parameter logic              INIT       = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ce,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*WORD_W-1:0]     in_data,
    output logic [LANES-1:0]            out_d0,
    output logic [LANES-1:0]            out_d1,
    output logic                        idle_insert,
    output logic                        underflow_err,
    input  logic                        clr_err,
    output logic [clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int     HALF       = WORD_W / 2;
    localparam phase_t LAST_PHASE = phase_t'(HALF - 1);

    if ((WORD_W % 2) != 0) begin : g_bad_word_w
        $error("ddr_word_serializer: WORD_W must be even");
    end
    if (HALF > (1 << PHASE_W)) begin : g_bad_phase_w
        $error("ddr_word_serializer: WORD_W too large for phase counter");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("ddr_word_serializer: FIFO_DEPTH must be a power of 2, at least 2");
    end

    logic [LANES-1:0][WORD_W-1:0] shift_q, shift_d;
    logic [LANES-1:0]             out_d0_q, out_d0_d;
    logic [LANES-1:0]             out_d1_q, out_d1_d;
    phase_t                       phase_q, phase_d;
    ser_state_t                   state_q, state_d;
    logic                         idle_insert_q, idle_insert_d;
    logic                         underflow_err_q, underflow_err_d;

    logic                         fifo_wr;
    logic                         fifo_rd;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [LANES*WORD_W-1:0]      fifo_rd_data;

    assign in_ready = ce & ~fifo_full;
    assign fifo_wr  = in_valid & in_ready;

    sync_fifo #(
        .WIDTH (LANES*WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (in_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Shift out two bits per lane each enabled cycle; reload at the last phase
    always_comb begin
        shift_d         = shift_q;
        out_d0_d        = out_d0_q;
        out_d1_d        = out_d1_q;
        phase_d         = phase_q;
        state_d         = state_q;
        idle_insert_d   = 1'b0;
        underflow_err_d = underflow_err_q;
        fifo_rd         = 1'b0;

        if (ce) begin
            if (clr_err) begin
                underflow_err_d = 1'b0;
            end
            for (int k = 0; k < LANES; k++) begin
                out_d0_d[k] = shift_q[k][0];
                out_d1_d[k] = shift_q[k][1];
                shift_d[k]  = shift_q[k] >> 2;
            end
            if (phase_q == LAST_PHASE) begin
                phase_d = '0;
                if (!fifo_empty) begin
                    shift_d = fifo_rd_data;
                    fifo_rd = 1'b1;
                    state_d = ST_DATA;
                end else begin
                    shift_d       = {LANES{IDLE_WORD}};
                    idle_insert_d = 1'b1;
                    if (state_q == ST_DATA) begin
                        underflow_err_d = 1'b1;
                        state_d         = ST_FILL;
                    end
                end
            end else begin
                phase_d = phase_q + phase_t'(1);
            end
        end
    end

    // Serializer state; reset restarts the idle stream at phase 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q         <= {LANES{IDLE_WORD}};
            out_d0_q        <= {LANES{INIT}};
            out_d1_q        <= {LANES{INIT}};
            phase_q         <= '0;
            state_q         <= ST_FILL;
            idle_insert_q   <= 1'b0;
            underflow_err_q <= 1'b0;
        end else begin
            shift_q         <= shift_d;
            out_d0_q        <= out_d0_d;
            out_d1_q        <= out_d1_d;
            phase_q         <= phase_d;
            state_q         <= state_d;
            idle_insert_q   <= idle_insert_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    assign out_d0        = out_d0_q;
    assign out_d1        = out_d1_q;
    assign idle_insert   = idle_insert_q;
    assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_ddr_word_serializer.sv
// Directed bench for ddr_word_serializer: idle stream, single word,
// back-to-back supply, clock-enable stall, mid-word reset and two lanes.
module tb_ddr_word_serializer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, ce, in_valid, in_ready, clr_err;
    logic [9:0]  in_data;
    logic [0:0]  out_d0, out_d1;
    logic        idle_insert, underflow_err;
    logic [2:0]  fifo_level;

    logic        rst2_n, ce2, in_valid2, in_ready2, clr_err2;
    logic [19:0] in_data2;
    logic [1:0]  out2_d0, out2_d1;
    logic        idle_insert2, underflow_err2;
    logic [2:0]  fifo_level2;

    int vectors     = 0;
    int miscompares = 0;
    int ph          = 0;

    // Pair patterns, bit i holds the value for pair i
    logic [4:0] IDLE_D0 = 5'b11110;
    logic [4:0] IDLE_D1 = 5'b00110;
    logic [4:0] W1E3_D0 = 5'b11001;
    logic [4:0] W1E3_D1 = 5'b01101;
    logic [4:0] W2D8_D0 = 5'b01100;
    logic [4:0] W2D8_D1 = 5'b11010;
    logic [4:0] W127_D0 = 5'b10011;
    logic [4:0] W127_D1 = 5'b00101;

    ddr_word_serializer #(.LANES(1)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_d0(out_d0), .out_d1(out_d1), .idle_insert(idle_insert),
        .underflow_err(underflow_err), .clr_err(clr_err), .fifo_level(fifo_level)
    );

    ddr_word_serializer #(.LANES(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .ce(ce2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .out_d0(out2_d0), .out_d1(out2_d1), .idle_insert(idle_insert2),
        .underflow_err(underflow_err2), .clr_err(clr_err2), .fifo_level(fifo_level2)
    );

    // Advance one clock and sample 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        if (ce === 1'b1 && rst_n === 1'b1) ph = (ph == 4) ? 0 : ph + 1;
    endtask

    task automatic align();
        while (ph != 0) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({out_d0, out_d1, idle_insert, underflow_err} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %b expected 0000", {out_d0, out_d1, idle_insert, underflow_err});
        end
        vectors++;
        if (fifo_level !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ph    = 0;
        for (int i = 0; i < 15; i++) begin
            logic [3:0] exp;
            step();
            exp = {IDLE_D0[i%5], IDLE_D1[i%5], (i % 5 == 4), 1'b0};
            vectors++;
            if ({out_d0, out_d1, idle_insert, underflow_err} !== exp) begin
                miscompares++;
                $display("[TB] FAIL idle_stream[%0d]: got %b expected %b", i, {out_d0, out_d1, idle_insert, underflow_err}, exp);
            end
        end
    endtask

    task automatic test_single_word();
        step();
        step();
        in_valid = 1'b1;
        in_data  = 10'h1E3;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_ready: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if (fifo_level !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL single_level_push: got %0d expected 1", fifo_level);
        end
        step();
        step();
        vectors++;
        if ({out_d0, out_d1, idle_insert, fifo_level} !== {IDLE_D0[4], IDLE_D1[4], 1'b0, 3'd0}) begin
            miscompares++;
            $display("[TB] FAIL single_load: got %b expected %b", {out_d0, out_d1, idle_insert, fifo_level}, {IDLE_D0[4], IDLE_D1[4], 1'b0, 3'd0});
        end
        for (int i = 0; i < 5; i++) begin
            logic [3:0] exp;
            step();
            exp = {W1E3_D0[i], W1E3_D1[i], (i == 4), (i == 4)};
            vectors++;
            if ({out_d0, out_d1, idle_insert, underflow_err} !== exp) begin
                miscompares++;
                $display("[TB] FAIL single_word[%0d]: got %b expected %b", i, {out_d0, out_d1, idle_insert, underflow_err}, exp);
            end
        end
        for (int i = 0; i < 5; i++) begin
            logic [3:0] exp;
            step();
            exp = {IDLE_D0[i], IDLE_D1[i], (i == 4), 1'b1};
            vectors++;
            if ({out_d0, out_d1, idle_insert, underflow_err} !== exp) begin
                miscompares++;
                $display("[TB] FAIL single_idle_after[%0d]: got %b expected %b", i, {out_d0, out_d1, idle_insert, underflow_err}, exp);
            end
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        vectors++;
        if (underflow_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_clr_err: got %b expected 0", underflow_err);
        end
        align();
    endtask

    task automatic test_back_to_back();
        logic [9:0] w [8];
        int         j;
        w = '{10'h1E3, 10'h0F0, 10'h3FF, 10'h001, 10'h155, 10'h2AA, 10'h283, 10'h31C};
        j = 0;
        for (int n = 1; n <= 50; n++) begin
            logic       pushed;
            logic [2:0] exp_level;
            logic [9:0] cw;
            logic [2:0] exp;
            int         p;
            in_valid = (j < 8);
            in_data  = (j < 8) ? w[j] : 10'h000;
            pushed   = in_valid && in_ready;
            step();
            if (pushed) j++;
            if (n <= 4)       exp_level = 3'(n);
            else if (n <= 21) exp_level = (n % 5 == 0) ? 3'd3 : 3'd4;
            else if (n < 25)  exp_level = 3'd4;
            else if (n < 40)  exp_level = 3'(8 - n / 5);
            else              exp_level = 3'd0;
            vectors++;
            if ({fifo_level, in_ready} !== {exp_level, (exp_level != 3'd4)}) begin
                miscompares++;
                $display("[TB] FAIL b2b_level[%0d]: got %0d/%b expected %0d/%b", n, fifo_level, in_ready, exp_level, (exp_level != 3'd4));
            end
            p = (n - 1) % 5;
            if (n >= 6 && n <= 45) begin
                cw  = w[(n - 6) / 5];
                exp = {cw[2*p], cw[2*p+1], 1'b0};
            end else begin
                exp = {IDLE_D0[p], IDLE_D1[p], 1'b0};
            end
            exp[0] = (n == 45 || n == 50);
            vectors++;
            if ({out_d0, out_d1, idle_insert} !== exp) begin
                miscompares++;
                $display("[TB] FAIL b2b_out[%0d]: got %b expected %b", n, {out_d0, out_d1, idle_insert}, exp);
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (j != 8) begin
            miscompares++;
            $display("[TB] FAIL b2b_accepted: got %0d expected 8", j);
        end
        vectors++;
        if (underflow_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_underflow: got %b expected 1", underflow_err);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        align();
    endtask

    task automatic test_ce_stall();
        in_valid = 1'b1;
        in_data  = 10'h2D8;
        step();
        in_data  = 10'h127;
        step();
        in_valid = 1'b0;
        vectors++;
        if (fifo_level !== 3'd2) begin
            miscompares++;
            $display("[TB] FAIL stall_level_pre: got %0d expected 2", fifo_level);
        end
        step();
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if ({out_d0, out_d1, fifo_level} !== {W2D8_D0[i], W2D8_D1[i], 3'd1}) begin
                miscompares++;
                $display("[TB] FAIL stall_before[%0d]: got %b expected %b", i, {out_d0, out_d1, fifo_level}, {W2D8_D0[i], W2D8_D1[i], 3'd1});
            end
        end
        ce       = 1'b0;
        in_valid = 1'b1;
        in_data  = 10'h3FF;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_ready: got %b expected 0", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({out_d0, out_d1, idle_insert, in_ready, fifo_level} !== {W2D8_D0[1], W2D8_D1[1], 1'b0, 1'b0, 3'd1}) begin
                miscompares++;
                $display("[TB] FAIL stall_hold[%0d]: got %b expected %b", i, {out_d0, out_d1, idle_insert, in_ready, fifo_level}, {W2D8_D0[1], W2D8_D1[1], 1'b0, 1'b0, 3'd1});
            end
        end
        ce       = 1'b1;
        in_valid = 1'b0;
        for (int i = 2; i < 5; i++) begin
            logic [2:0] exp_level;
            step();
            exp_level = (i == 4) ? 3'd0 : 3'd1;
            vectors++;
            if ({out_d0, out_d1, idle_insert, fifo_level} !== {W2D8_D0[i], W2D8_D1[i], 1'b0, exp_level}) begin
                miscompares++;
                $display("[TB] FAIL stall_resume[%0d]: got %b expected %b", i, {out_d0, out_d1, idle_insert, fifo_level}, {W2D8_D0[i], W2D8_D1[i], 1'b0, exp_level});
            end
        end
        for (int i = 0; i < 5; i++) begin
            logic [3:0] exp;
            clr_err = (i == 4);
            step();
            exp = {W127_D0[i], W127_D1[i], (i == 4), (i == 4)};
            vectors++;
            if ({out_d0, out_d1, idle_insert, underflow_err} !== exp) begin
                miscompares++;
                $display("[TB] FAIL stall_second_word[%0d]: got %b expected %b", i, {out_d0, out_d1, idle_insert, underflow_err}, exp);
            end
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        vectors++;
        if (underflow_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_clr_err: got %b expected 0", underflow_err);
        end
        align();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        in_data  = 10'h3FF;
        step();
        in_data  = 10'h155;
        step();
        in_data  = 10'h2AA;
        step();
        in_valid = 1'b0;
        step();
        step();
        in_valid = 1'b1;
        in_data  = 10'h0F0;
        step();
        in_valid = 1'b0;
        step();
        vectors++;
        if ({out_d0, out_d1, fifo_level} !== {2'b11, 3'd3}) begin
            miscompares++;
            $display("[TB] FAIL midrst_before: got %b expected %b", {out_d0, out_d1, fifo_level}, {2'b11, 3'd3});
        end
        rst_n = 1'b0;
        #2;
        vectors++;
        if ({out_d0, out_d1, idle_insert, underflow_err, fifo_level} !== 7'b0000_000) begin
            miscompares++;
            $display("[TB] FAIL midrst_async: got %b expected 0000000", {out_d0, out_d1, idle_insert, underflow_err, fifo_level});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ph    = 0;
        for (int i = 0; i < 10; i++) begin
            logic [6:0] exp;
            step();
            exp = {IDLE_D0[i%5], IDLE_D1[i%5], (i % 5 == 4), 1'b0, 3'd0};
            vectors++;
            if ({out_d0, out_d1, idle_insert, underflow_err, fifo_level} !== exp) begin
                miscompares++;
                $display("[TB] FAIL midrst_restart[%0d]: got %b expected %b", i, {out_d0, out_d1, idle_insert, underflow_err, fifo_level}, exp);
            end
        end
    endtask

    task automatic test_two_lanes();
        vectors++;
        if ({out2_d0, out2_d1} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL lanes_reset: got %b expected 0000", {out2_d0, out2_d1});
        end
        @(posedge clk);
        #1;
        rst2_n   = 1'b1;
        in_data2 = {10'h17C, 10'h1E3};
        for (int i = 0; i < 10; i++) begin
            logic [4:0] exp;
            logic [2:0] exp_level;
            int         p;
            in_valid2 = (i == 0);
            step();
            p = i % 5;
            if (i < 5) exp = {IDLE_D0[p], IDLE_D0[p], IDLE_D1[p], IDLE_D1[p], 1'b0};
            else       exp = {IDLE_D0[p], W1E3_D0[p], IDLE_D1[p], W1E3_D1[p], (i == 9)};
            exp_level = (i < 4) ? 3'd1 : 3'd0;
            vectors++;
            if ({out2_d0, out2_d1, idle_insert2, fifo_level2} !== {exp, exp_level}) begin
                miscompares++;
                $display("[TB] FAIL lanes_out[%0d]: got %b expected %b", i, {out2_d0, out2_d1, idle_insert2, fifo_level2}, {exp, exp_level});
            end
        end
        in_valid2 = 1'b0;
        vectors++;
        if (underflow_err2 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL lanes_underflow: got %b expected 1", underflow_err2);
        end
    endtask

    // Guard against a stuck simulation
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        ce        = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        clr_err   = 1'b0;
        rst2_n    = 1'b0;
        ce2       = 1'b1;
        in_valid2 = 1'b0;
        in_data2  = '0;
        clr_err2  = 1'b0;

        test_reset();
        test_single_word();
        test_back_to_back();
        test_ce_stall();
        test_reset_mid();
        test_two_lanes();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
